// File: rtl/crc32_check_if.sv
// Checker request/result bundle: word + received CRC in, busy/valid/ok (+syndrome) out.
// No latency of its own; pure wiring between requester and checker.
// Requester must hold off ld while busy=1; the checker drops such loads.
// Optional syndrome signal exists only when CRC32_CHECK_SYNDROME_EN is defined.
interface crc32_check_if;
    logic [31:0] data;
    logic [31:0] crc_in;
    logic        ld;
    logic        busy;
    logic        valid;
    logic        ok;
`ifdef CRC32_CHECK_SYNDROME_EN
    logic [31:0] syndrome;
`endif

    // Requester side: presents the word, watches the result.
    modport master (
        output data, crc_in, ld,
        input  busy, valid, ok
`ifdef CRC32_CHECK_SYNDROME_EN
        , syndrome
`endif
    );

    // Checker side.
    modport slave (
        input  data, crc_in, ld,
        output busy, valid, ok
`ifdef CRC32_CHECK_SYNDROME_EN
        , syndrome
`endif
    );
endinterface

// File: rtl/crc32_check.sv
// Bit-serial CRC-32 checker: divides {data, crc_in} by 0x1_04C11DB7, reports zero remainder.
// Latency: load at edge E, valid/ok after edge E+64; one word per 65 cycles back-to-back.
// Backpressure: ld is ignored while busy=1 (no queueing); accepted in IDLE and in the valid cycle.
// Optional feature macro: CRC32_CHECK_SYNDROME_EN exposes the final remainder as syndrome.
module crc32_check (
    input  logic         clk,
    input  logic         rst,
    crc32_check_if.slave bus
);
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  SHIFT = 2'd1;
    localparam logic [1:0]  DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] msg_q, msg_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic [31:0] rem_next;
`ifdef CRC32_CHECK_SYNDROME_EN
    logic [31:0] syndrome_q, syndrome_d;
`endif

    // One division step: shift in the next codeword bit, subtract the polynomial on carry-out.
    always_comb begin
        rem_next = {rem_q[30:0], msg_q[63]} ^ (rem_q[31] ? POLY : 32'd0);
    end

    // Next-state logic: load in IDLE/DONE, shift in SHIFT, finish after the 64th bit.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
`ifdef CRC32_CHECK_SYNDROME_EN
        syndrome_d = syndrome_q;
`endif
        case (state_q)
            SHIFT: begin
                rem_d = rem_next;
                msg_d = msg_q << 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = DONE;
                    ok_d    = (rem_next == 32'd0);
`ifdef CRC32_CHECK_SYNDROME_EN
                    syndrome_d = rem_next;
`endif
                end
            end
            default: begin
                // IDLE and DONE both accept a load; DONE otherwise falls back to IDLE.
                if (bus.ld) begin
                    state_d = SHIFT;
                    msg_d   = {bus.data, bus.crc_in};
                    rem_d   = 32'd0;
                    cnt_d   = 6'd0;
                    ok_d    = 1'b0;   // no stale pass while the new word is in flight
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State registers; reset wins over loads and aborts an in-flight division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= 64'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 6'd0;
            ok_q    <= 1'b0;
`ifdef CRC32_CHECK_SYNDROME_EN
            syndrome_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
`ifdef CRC32_CHECK_SYNDROME_EN
            syndrome_q <= syndrome_d;
`endif
        end
    end

    // DONE lasts exactly one cycle, so it doubles as the valid pulse.
    always_comb begin
        bus.busy  = (state_q == SHIFT);
        bus.valid = (state_q == DONE);
        bus.ok    = ok_q;
`ifdef CRC32_CHECK_SYNDROME_EN
        bus.syndrome = syndrome_q;
`endif
    end
endmodule

// File: tb/tb_crc32_check.sv
// Self-checking bench for crc32_check: directed vectors, random words, back-to-back,
// ignored mid-division loads and reset abort, all against a long-division reference.
module tb_crc32_check;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    crc32_check_if bus ();
    crc32_check dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: remainder of the 64-bit codeword modulo the 33-bit polynomial, by long division.
    function automatic logic [31:0] ref_rem(input logic [31:0] d, input logic [31:0] c);
        logic [63:0] m;
        logic [63:0] p;
        m = {d, c};
        p = 64'h1_04C1_1DB7;
        for (int i = 63; i >= 32; i--)
            if (m[i]) m = m ^ (p << (i - 32));
        return m[31:0];
    endfunction

    function automatic logic [31:0] ref_crc(input logic [31:0] d);
        return ref_rem(d, 32'd0);
    endfunction

    // Load one word, follow it to completion, check timing and results.
    task automatic run_word(input logic [31:0] d, input logic [31:0] c, input string name);
        logic [31:0] exp_rem;
        int busy_n;
        int t;
        bit seen;
        bit overlap;
        bit stale;
        exp_rem = ref_rem(d, c);
        busy_n = 0; seen = 0; overlap = 0; stale = 0; t = 0;
        @(negedge clk);
        bus.data = d; bus.crc_in = c; bus.ld = 1'b1;
        @(negedge clk);
        bus.ld = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            t = k;
            if (bus.busy && bus.valid) overlap = 1;
            if (bus.busy) begin
                busy_n++;
                if (bus.ok !== 1'b0) stale = 1;
            end
            if (bus.valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no valid pulse within 200 cycles", name);
            return;
        end
        checks++;
        if (t !== 65) begin errors++; $display("FAIL %s valid_latency: got %0d want 65", name, t); end
        checks++;
        if (busy_n !== 64) begin errors++; $display("FAIL %s busy_cycles: got %0d want 64", name, busy_n); end
        checks++;
        if (overlap || stale) begin errors++; $display("FAIL %s busy_overlap_or_stale_ok: overlap=%0d stale=%0d want 0 0", name, overlap, stale); end
        checks++;
        if (bus.ok !== (exp_rem == 32'd0)) begin errors++; $display("FAIL %s ok: got %b want %b", name, bus.ok, exp_rem == 32'd0); end
`ifdef CRC32_CHECK_SYNDROME_EN
        checks++;
        if (bus.syndrome !== exp_rem) begin errors++; $display("FAIL %s syndrome: got %h want %h", name, bus.syndrome, exp_rem); end
`endif
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s after_valid: valid=%b busy=%b want 0 0", name, bus.valid, bus.busy);
        end
        checks++;
        if (bus.ok !== (exp_rem == 32'd0)) begin errors++; $display("FAIL %s ok_hold: got %b want %b", name, bus.ok, exp_rem == 32'd0); end
    endtask

    task automatic check_idle_reset(input string name);
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.ok !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b valid=%b ok=%b want 0 0 0", name, bus.busy, bus.valid, bus.ok);
        end
`ifdef CRC32_CHECK_SYNDROME_EN
        checks++;
        if (bus.syndrome !== 32'd0) begin errors++; $display("FAIL %s syndrome: got %h want 0", name, bus.syndrome); end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle_reset("reset_idle");
        end
    endtask

    task automatic test_vectors();
        run_word(32'h0000_0001, 32'h04C1_1DB7, "vec_good");
        run_word(32'h0000_0002, 32'h0000_0000, "vec_zero_crc");
        run_word(32'h0000_0001, 32'h04C1_1DB6, "vec_bit_err");
        // Hand-derived remainders double-check the reference itself.
        checks++;
        if (ref_rem(32'h2, 32'h0) !== 32'h09823B6E || ref_rem(32'h1, 32'h04C11DB6) !== 32'h1) begin
            errors++; $display("FAIL ref_model_vectors: got %h %h want 09823b6e 00000001",
                               ref_rem(32'h2, 32'h0), ref_rem(32'h1, 32'h04C11DB6));
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] c;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            case (i % 3)
                0: c = ref_crc(d);
                1: c = ref_crc(d) ^ (32'd1 << $urandom_range(31, 0));
                default: c = $urandom;
            endcase
            run_word(d, c, "random");
        end
    endtask

    // A stray ld pulse mid-division must neither change the result nor queue a second word.
    task automatic test_busy_ignore();
        int t;
        bit seen;
        seen = 0; t = 0;
        @(negedge clk);
        bus.data = 32'h0000_0001; bus.crc_in = 32'h04C1_1DB7; bus.ld = 1'b1;
        @(negedge clk);
        bus.ld = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            t = k;
            if (k == 10) begin
                bus.data = 32'hDEAD_BEEF; bus.crc_in = 32'h1234_5678; bus.ld = 1'b1;
            end else begin
                bus.ld = 1'b0;
            end
            if (bus.valid === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || t !== 65 || bus.ok !== 1'b1) begin
            errors++; $display("FAIL busy_ignore: seen=%0d latency=%0d ok=%b want 1 65 1", seen, t, bus.ok);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_queued: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int vidx[$];
        bit overlap;
        bit bad_ok;
        overlap = 0; bad_ok = 0;
        @(negedge clk);
        bus.data = 32'd0; bus.crc_in = 32'd0; bus.ld = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 200; k++) begin
            if (bus.busy && bus.valid) overlap = 1;
            if (bus.valid === 1'b1) begin
                vidx.push_back(k);
                if (bus.ok !== 1'b1) bad_ok = 1;
            end
            if (k == 25 || k == 100) begin
                bus.data = $urandom | 32'h1; bus.crc_in = $urandom;
            end else begin
                bus.data = 32'd0; bus.crc_in = 32'd0;
            end
            if (k == 195) bus.ld = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (vidx.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d pulses want 3", vidx.size());
        end else begin
            checks++;
            if (vidx[0] != 65 || vidx[1] != 130 || vidx[2] != 195) begin
                errors++; $display("FAIL b2b_spacing: got %0d %0d %0d want 65 130 195", vidx[0], vidx[1], vidx[2]);
            end
        end
        checks++;
        if (overlap || bad_ok) begin errors++; $display("FAIL b2b_flags: overlap=%0d bad_ok=%0d want 0 0", overlap, bad_ok); end
    endtask

    task automatic test_rst_abort();
        bit seen;
        seen = 0;
        @(negedge clk);
        bus.data = 32'h0000_0001; bus.crc_in = 32'h04C1_1DB7; bus.ld = 1'b1;
        @(negedge clk);
        bus.ld = 1'b0;
        for (int k = 1; k < 30; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset("rst_abort_outputs");
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_abort_quiet: activity seen=%0d want 0", seen); end
        run_word(32'h0000_0001, 32'h04C1_1DB7, "post_rst_load");
    endtask

    initial begin
        bus.data = 32'd0;
        bus.crc_in = 32'd0;
        bus.ld = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
